// File: rtl/led_sel_pkg.sv
// Shared constants and helpers for the one-hot LED selector.
//   MODE_DIRECT / MODE_STEP : values of the synchronised mode switch
//   DEB_CYCLES_DEF          : default debounce length (1 ms at 12 MHz)
//   BLINK_CYCLES_DEF        : default blink half-period (0.5 s at 12 MHz)
//   cnt_width()             : counter width able to hold 0..n-1, never below 1
package led_sel_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_STEP   = 1'b1;

  localparam int unsigned DEB_CYCLES_DEF   = 12000;
  localparam int unsigned BLINK_CYCLES_DEF = 6000000;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_onehot_sel_btn_debounce.sv
// Single-bit button conditioner: 2-flop synchroniser followed by a
// consecutive-stable-cycle debouncer.
//   clk, rst : clock, synchronous active-high reset
//   btn_i    : raw asynchronous button
//   deb_o    : debounced level (registered)
module btn_debounce
  import led_sel_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic deb_o
);

  localparam int unsigned CW = cnt_width(DEB_CYCLES);

  logic          sync1_q, sync2_q;
  logic          state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter runs only while the synced input disagrees with the accepted state.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    if (sync2_q != state_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        state_d = ~state_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign deb_o = state_q;

endmodule

// File: rtl/led_onehot_sel.sv
// Button-to-one-hot LED selector. N_BTN debounced buttons either form the
// LED index directly (mode=0) or step the lit LED up/down with wrap (mode=1).
//   clk, rst : clock, synchronous active-high reset
//   btn      : raw buttons, btn[0] = index LSB / step-up, btn[1] = step-down
//   mode     : raw mode switch, 0 = direct, 1 = step
//   led      : one-hot LED drive (registered)
//   idx      : binary index of the lit LED (registered)
// Optional macro LED_SEL_BLINK_EN: in step mode the lit LED blinks with
// half-period BLINK_CYCLES; led is all-zero during the off phase.
module led_onehot_sel
  import led_sel_pkg::*;
#(
  parameter int unsigned N_BTN        = 2,
  parameter int unsigned DEB_CYCLES   = DEB_CYCLES_DEF,
  parameter int unsigned BLINK_CYCLES = BLINK_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_BTN-1:0]      btn,
  input  logic                  mode,
  output logic [2**N_BTN-1:0]   led,
  output logic [N_BTN-1:0]      idx
);

  localparam int unsigned N_LED = 2**N_BTN;

  if (N_BTN < 2 || N_BTN > 4 || DEB_CYCLES < 1 || BLINK_CYCLES < 1) begin : g_bad_param
    $error("led_onehot_sel: illegal parameter set");
  end

  logic [N_BTN-1:0] deb;
  logic             mode_s1_q, mode_s_q;
  logic [1:0]       deb_prev_q, deb_prev_d;
  logic [N_BTN-1:0] idx_q, idx_d;
  logic [N_LED-1:0] led_q, led_d;
  logic [N_LED-1:0] led_hot;
  logic             up_edge, dn_edge;

  for (genvar i = 0; i < int'(N_BTN); i++) begin : g_btn
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .rst   (rst),
      .btn_i (btn[i]),
      .deb_o (deb[i])
    );
  end

  // Previous-state register tracks in both modes, so a button held across
  // the switch into step mode never looks like a fresh press.
  assign up_edge    = deb[0] & ~deb_prev_q[0];
  assign dn_edge    = deb[1] & ~deb_prev_q[1];
  assign deb_prev_d = deb[1:0];

  // Next index: direct load, or +/-1 (natural wrap) on a lone edge.
  always_comb begin
    idx_d = idx_q;
    if (mode_s_q == MODE_DIRECT) begin
      idx_d = deb;
    end else if (up_edge && !dn_edge) begin
      idx_d = idx_q + N_BTN'(1);
    end else if (dn_edge && !up_edge) begin
      idx_d = idx_q - N_BTN'(1);
    end
  end

  assign led_hot = N_LED'(1) << idx_d;

`ifdef LED_SEL_BLINK_EN
  localparam int unsigned BW = cnt_width(BLINK_CYCLES);

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_on_q, blink_on_d;

  // Blink restarts on-phase whenever the index moves or in direct mode.
  always_comb begin
    blink_cnt_d = blink_cnt_q + BW'(1);
    blink_on_d  = blink_on_q;
    if (mode_s_q != MODE_STEP || idx_d != idx_q) begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end else if (blink_cnt_q == BW'(BLINK_CYCLES - 1)) begin
      blink_cnt_d = '0;
      blink_on_d  = ~blink_on_q;
    end
    led_d = blink_on_d ? led_hot : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end
`else
  always_comb begin
    led_d = led_hot;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_s1_q  <= 1'b0;
      mode_s_q   <= 1'b0;
      deb_prev_q <= '0;
      idx_q      <= '0;
      led_q      <= N_LED'(1);
    end else begin
      mode_s1_q  <= mode;
      mode_s_q   <= mode_s1_q;
      deb_prev_q <= deb_prev_d;
      idx_q      <= idx_d;
      led_q      <= led_d;
    end
  end

  assign led = led_q;
  assign idx = idx_q;

endmodule

// File: tb/tb_led_onehot_sel.sv
module tb_led_onehot_sel;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] btn;
  logic       mode;
  logic [3:0] led;
  logic [1:0] idx;

  int n_cmp  = 0;
  int n_fail = 0;

  led_onehot_sel #(.N_BTN(2), .DEB_CYCLES(DEB), .BLINK_CYCLES(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn),
    .mode (mode),
    .led  (led),
    .idx  (idx)
  );

  always #5 clk = ~clk;

  // Reference model: raw input seen two edges late, a level is accepted after
  // DEB consecutive disagreeing synced cycles, index follows the rules.
  bit   mvalid = 0;
  bit   m_s1 [2], m_s2 [2], m_deb [2], m_prev [2];
  int   m_run [2];
  bit   m_ms1, m_ms;
  int   m_idx;

  task automatic model_edge();
    bit   o_deb [2];
    bit   o_prev [2];
    int   up, dn;
    if (rst) begin
      mvalid = 1;
      for (int i = 0; i < 2; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_deb[i] = 0; m_prev[i] = 0; m_run[i] = 0;
      end
      m_ms1 = 0; m_ms = 0; m_idx = 0;
      return;
    end
    o_deb  = m_deb;
    o_prev = m_prev;
    up = (o_deb[0] && !o_prev[0]) ? 1 : 0;
    dn = (o_deb[1] && !o_prev[1]) ? 1 : 0;
    if (!m_ms) m_idx = int'(o_deb[1]) * 2 + int'(o_deb[0]);
    else       m_idx = (m_idx + 4 + up - dn) % 4;
    for (int i = 0; i < 2; i++) begin
      if (m_s2[i] != m_deb[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_deb[i] = ~m_deb[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
      m_prev[i] = o_deb[i];
      m_s2[i]   = m_s1[i];
      m_s1[i]   = btn[i];
    end
    m_ms  = m_ms1;
    m_ms1 = mode;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    if (mvalid) begin
      chk("model_idx", 32'(idx), 32'(m_idx));
      chk("model_led", 32'(led), 32'(1 << m_idx));
      chk("onehot", 32'($countones(led)), 32'd1);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press(input logic [1:0] v);
    btn = v;
    ticks(8);
    btn = 2'b00;
    ticks(8);
  endtask

  initial begin
    rst = 1'b1; btn = 2'b11; mode = 1'b0;

    // Reset with buttons held
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_led", 32'(led), 32'h1);
      chk("rst_idx", 32'(idx), 32'h0);
    end
    rst = 1'b0;
    for (int i = 0; i < DEB + 2; i++) begin
      tick();
      chk("post_rst_led", 32'(led), 32'h1);
    end
    tick();
    chk("first_decode_led", 32'(led), 32'h8);

    // Direct decode latency
    btn = 2'b10;
    for (int i = 0; i < DEB + 2; i++) begin
      tick();
      chk("dir10_hold", 32'(led), 32'h8);
    end
    tick();
    chk("dir10_led", 32'(led), 32'h4);
    btn = 2'b11;
    for (int i = 0; i < DEB + 2; i++) begin
      tick();
      chk("dir11_hold", 32'(led), 32'h4);
    end
    tick();
    chk("dir11_led", 32'(led), 32'h8);

    // Glitch reject
    btn = 2'b00;
    ticks(10);
    chk("dir00_led", 32'(led), 32'h1);
    btn = 2'b01;
    ticks(DEB - 1);
    btn = 2'b00;
    ticks(10);
    chk("glitch_led", 32'(led), 32'h1);
    chk("glitch_cnt", 32'(dut.g_btn[0].u_deb.cnt_q), 32'h0);

    // Step mode with wrap
    mode = 1'b1;
    ticks(10);
    chk("step_start", 32'(idx), 32'h0);
    for (int k = 1; k <= 4; k++) begin
      press(2'b01);
      chk("step_up", 32'(idx), 32'(k % 4));
    end
    press(2'b10);
    chk("step_dn_idx", 32'(idx), 32'h3);
    chk("step_dn_led", 32'(led), 32'h8);

    // Simultaneous up/down
    press(2'b11);
    chk("simul_idx", 32'(idx), 32'h3);
    press(2'b10);
    chk("after_simul", 32'(idx), 32'h2);

    // Mode switch while holding a button
    mode = 1'b0; btn = 2'b01;
    ticks(10);
    chk("ms_direct", 32'(idx), 32'h1);
    mode = 1'b1;
    ticks(10);
    chk("ms_step_hold", 32'(idx), 32'h1);
    btn = 2'b00;
    ticks(10);
    chk("ms_release", 32'(idx), 32'h1);
    mode = 1'b0;
    ticks(3);
    chk("ms_back", 32'(idx), 32'h0);
    chk("ms_back_led", 32'(led), 32'h1);

    // Randomised traffic against the model
    for (int s = 0; s < 120; s++) begin
      btn = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) mode = ~mode;
      rst = ($urandom_range(0, 40) == 0);
      tick();
      rst = 1'b0;
      ticks($urandom_range(1, 10));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
